// File: rtl/m31_addsub_vec.sv
// Multi-lane M31 (p = 2^31-1) adder/subtractor, two-stage valid/ready pipeline.
// Stage 1 forms the raw 32-bit sum; stage 2 folds it back to a canonical residue.
`timescale 1ns/1ps
module m31_addsub_vec #(
  parameter int LANES = 4,
  parameter int TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [LANES*31-1:0] a_i,
  input  logic [LANES*31-1:0] b_i,
  input  logic [LANES-1:0]    op_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [LANES*31-1:0] res_o,
  output logic [TAG_W-1:0]    tag_o
);

  localparam logic [30:0] P = 31'h7FFF_FFFF;

  logic             adv;
  logic             s1_valid_reg;
  logic             out_valid_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic [TAG_W-1:0] out_tag_reg;

  // Both stages move together, so a stalled output freezes the whole pipe.
  assign adv         = ~out_valid_reg | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_reg;
  assign tag_o       = out_tag_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      s1_tag_reg    <= '0;
      out_tag_reg   <= '0;
    end else if (adv) begin
      s1_valid_reg  <= in_valid_i;
      out_valid_reg <= s1_valid_reg;
      s1_tag_reg    <= tag_i;
      out_tag_reg   <= s1_tag_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [30:0] a_lane;
      logic [30:0] b_lane;
      logic [30:0] b_eff;
      logic [31:0] raw_next;
      logic [31:0] raw_reg;
      logic [30:0] fold;
      logic [30:0] res_next;
      logic [30:0] res_reg;

      assign a_lane = a_i[gi*31 +: 31];
      assign b_lane = b_i[gi*31 +: 31];
      // ~b equals p - b, so subtraction reuses the adder with no extra carry-in.
      assign b_eff    = op_i[gi] ? ~b_lane : b_lane;
      assign raw_next = {1'b0, a_lane} + {1'b0, b_eff};

      // raw <= 2p, so the end-around fold never overflows 31 bits.
      assign fold     = raw_reg[30:0] + {30'd0, raw_reg[31]};
      assign res_next = (fold == P) ? 31'd0 : fold;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          raw_reg <= '0;
          res_reg <= '0;
        end else if (adv) begin
          raw_reg <= raw_next;
          res_reg <= res_next;
        end
      end

      assign res_o[gi*31 +: 31] = res_reg;
    end
  endgenerate

endmodule

// File: tb/tb_m31_addsub_vec.sv
// Bench for m31_addsub_vec: directed vectors plus a queue-based (a +/- b) mod p model.
`timescale 1ns/1ps
module tb_m31_addsub_vec;
  localparam int LANES = 4;
  localparam int TAG_W = 8;
  localparam longint P = 64'h7FFF_FFFF;
  localparam logic [30:0] P31 = 31'h7FFF_FFFF;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*31-1:0] a = '0;
  logic [LANES*31-1:0] b = '0;
  logic [LANES-1:0]    op = '0;
  logic [TAG_W-1:0]    tag = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [LANES*31-1:0] res;
  logic [TAG_W-1:0]    tag_out;

  m31_addsub_vec #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .op_i(op), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .res_o(res), .tag_o(tag_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int out_count = 0;

  typedef struct {
    logic [LANES*31-1:0] res;
    logic [TAG_W-1:0]    tag;
    int                  edge_n;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain modular arithmetic on reduced operands.
  function automatic logic [LANES*31-1:0] model(input logic [LANES*31-1:0] av,
                                                input logic [LANES*31-1:0] bv,
                                                input logic [LANES-1:0] ov);
    logic [LANES*31-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      longint x, y, z;
      x = longint'({33'd0, av[i*31 +: 31]}) % P;
      y = longint'({33'd0, bv[i*31 +: 31]}) % P;
      z = ov[i] ? (x - y + P) % P : (x + y) % P;
      r[i*31 +: 31] = z[30:0];
    end
    return r;
  endfunction

  function automatic logic [LANES*31-1:0] rnd_vec();
    logic [LANES*31-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*31 +: 31] = 31'($urandom_range(0, 32'h7FFF_FFFF));
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: one pass per cycle, sampled on the falling edge.
  logic [LANES*31-1:0] held_res;
  logic [TAG_W-1:0]    held_tag;
  bit                  hold = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      exp_t e;
      bit   exp_ov;
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      // A beat accepted at edge N is presented after edge N+1 when it is the oldest.
      exp_ov = (q.size() > 0) && (q[0].edge_n < cyc);
      check("out_valid_timing", out_valid, exp_ov);
      if (hold) begin
        check("hold_res", res, held_res);
        check("hold_tag", tag_out, held_tag);
      end
      if (out_valid && out_ready) begin
        out_count++;
        $display("beat out tag=%0h res=%0h", tag_out, res);
        for (int i = 0; i < LANES; i++)
          check("canonical", res[i*31 +: 31] == P31, 1'b0);
        if (q.size() == 0) begin
          check("unexpected_beat", out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          check("res", res, e.res);
          check("tag", tag_out, e.tag);
        end
      end
      hold     = out_valid && !out_ready;
      held_res = res;
      held_tag = tag_out;
      if (in_valid && in_ready) begin
        e.res    = model(a, b, op);
        e.tag    = tag;
        e.edge_n = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [LANES*31-1:0] av, input logic [LANES*31-1:0] bv,
                      input logic [LANES-1:0] ov, input logic [TAG_W-1:0] tv,
                      output int waits);
    bit acc;
    waits    = 0;
    a        = av;
    b        = bv;
    op       = ov;
    tag      = tv;
    in_valid = 1'b1;
    acc      = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waits++;
        if (waits > 50) begin
          check("send_timeout", in_ready, 1'b1);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, tot_w, c0;
    bit acc;
    logic [TAG_W-1:0] t;

    // Reset state
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_res", res, '0);
    check("rst_tag", tag_out, '0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Basic add/sub, latency 2
    send({31'h7FFF_FFFE, 31'd5, 31'd3, 31'd5}, {31'd1, 31'd5, 31'd5, 31'd7}, 4'b0110, 8'hA5, w);
    @(negedge clk);
    check("lat_s1_not_valid", out_valid, 1'b0);
    @(negedge clk);
    check("lat_valid", out_valid, 1'b1);
    check("basic_res", res, {31'd0, 31'd0, 31'h7FFF_FFFD, 31'd12});
    check("basic_tag", tag_out, 8'hA5);
    @(posedge clk);
    #1;

    // Non-canonical inputs and worst-case folds
    send({31'd0, P31, 31'd4, P31}, {31'd0, P31, P31, 31'd9}, 4'b1010, 8'h3C, w);
    @(negedge clk);
    @(negedge clk);
    check("noncanon_res", res, {31'd0, 31'd0, 31'd4, 31'd9});
    check("noncanon_tag", tag_out, 8'h3C);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: six tagged beats, output held for four cycles
    fork
      begin
        for (int i = 1; i <= 6; i++) send(rnd_vec(), rnd_vec(), LANES'($urandom), 8'(i), w);
      end
      begin
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Full throughput
    tot_w = 0;
    c0 = out_count;
    for (int i = 0; i < 100; i++) begin
      send(rnd_vec(), rnd_vec(), LANES'($urandom), 8'(i), w);
      tot_w += w;
    end
    repeat (2) @(negedge clk);
    check("thru_no_stall", tot_w, 0);
    check("thru_count", out_count - c0, 100);
    @(posedge clk);
    #1;
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(rnd_vec(), rnd_vec(), LANES'($urandom), 8'h77, w);
    send(rnd_vec(), rnd_vec(), LANES'($urandom), 8'h78, w);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_res", res, '0);
    check("midrst_tag", tag_out, '0);
    q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Random bubbles on both sides
    t = 8'h00;
    acc = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        if (in_valid) begin
          a   = rnd_vec();
          b   = rnd_vec();
          op  = LANES'($urandom);
          tag = t;
          t++;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
